// File: rtl/eth_sw_pkg.sv
// Shared definitions for the Ethernet switch egress path.
// Holds the TX arbiter state codes, the default data-path parameters and a
// small helper that sizes requester index fields.
package eth_sw_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_REQ    = 3;
  // 6 cycles TX pipeline drain + 12 inter-frame gap + 2 margin
  localparam int unsigned DEF_IFG        = 20;
  localparam int unsigned DEF_MAX_LEN    = 1522;

  localparam int unsigned STATE_W = 2;

  // Codes are observed by the TX port CRC checker, so they are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE         = 2'b00,
    ST_FORM_REQUEST = 2'b01,
    ST_XFER         = 2'b10,
    ST_GAP          = 2'b11
  } tx_state_e;

  // Width of an index field able to address n requesters (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at ptr+1 and wrapping, returning the first set bit.
// Ports:
//   req          - request vector, one bit per requester
//   ptr          - index of the requester served last
//   winner_c     - one-hot winner (all zero when no request)
//   winner_idx_c - binary index of the winner
//   found_c      - at least one request present
module rr_pick
  import eth_sw_pkg::*;
#(
  parameter int unsigned pNUM_REQ = DEF_NUM_REQ,
  parameter int unsigned pIDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [pNUM_REQ-1:0] req,
  input  logic [pIDX_W-1:0]   ptr,
  output logic [pNUM_REQ-1:0] winner_c,
  output logic [pIDX_W-1:0]   winner_idx_c,
  output logic                found_c
);

  // Candidate = ptr + off (1..N), wrapped by a single subtraction since the
  // sum is always below 2*N.
  always_comb begin
    int unsigned cand;
    logic [pIDX_W-1:0] cand_idx;
    cand         = 0;
    cand_idx     = '0;
    winner_c     = '0;
    winner_idx_c = '0;
    found_c      = 1'b0;
    for (int unsigned off = 1; off <= pNUM_REQ; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= pNUM_REQ) begin
        cand = cand - pNUM_REQ;
      end
      cand_idx = pIDX_W'(cand);
      if (!found_c && req[cand_idx]) begin
        found_c            = 1'b1;
        winner_idx_c       = cand_idx;
        winner_c[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_port_arbiter.sv
// Egress TX port arbiter: shares one TX port between pNUM_REQ ingress
// requesters, one whole frame at a time, with round-robin fairness and a
// fixed idle gap after every frame.
// Ports:
//   i_clk, i_rst      - clock, synchronous active-high reset
//   i_req             - per-requester frame-ready request
//   i_data            - flattened per-requester bytes, requester k in slice k
//   i_valid, i_last   - per-requester byte valid / last-byte marker
//   o_grant           - one-hot grant (zero when nobody owns the port)
//   o_TX_data_valid   - byte valid to the TX port
//   o_TX_finish       - single-cycle end-of-frame pulse
//   o_data_TX         - byte to the TX port (zero when not valid)
//   o_state           - current state code for the CRC checker
//   o_busy            - high in every state except IDLE
//   o_err_len         - single-cycle pulse on oversize-frame abort
module tx_port_arbiter
  import eth_sw_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned pNUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned pIFG        = DEF_IFG,
  parameter int unsigned pMAX_LEN    = DEF_MAX_LEN
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [pNUM_REQ-1:0]             i_req,
  input  logic [pNUM_REQ*pDATA_WIDTH-1:0] i_data,
  input  logic [pNUM_REQ-1:0]             i_valid,
  input  logic [pNUM_REQ-1:0]             i_last,
  output logic [pNUM_REQ-1:0]             o_grant,
  output logic                            o_TX_data_valid,
  output logic                            o_TX_finish,
  output logic [pDATA_WIDTH-1:0]          o_data_TX,
  output logic [STATE_W-1:0]              o_state,
  output logic                            o_busy,
  output logic                            o_err_len
);

  localparam int unsigned IDX_W  = idx_width(pNUM_REQ);
  localparam int unsigned BEAT_W = $clog2(pMAX_LEN + 1);
  localparam int unsigned GAP_W  = $clog2(pIFG + 1);

  tx_state_e            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic [pNUM_REQ-1:0]    grant_d;
  logic                   dv_d;
  logic                   fin_d;
  logic [pDATA_WIDTH-1:0] data_d;
  logic                   busy_d;
  logic                   err_d;

  logic [pNUM_REQ-1:0]    pick_grant_c;
  logic [IDX_W-1:0]       pick_idx_c;
  logic                   pick_found_c;

  logic [pDATA_WIDTH-1:0] data_arr [pNUM_REQ];
  logic                   sel_valid_c;
  logic                   sel_last_c;
  logic [pDATA_WIDTH-1:0] sel_data_c;

  // Unflatten the byte bus so the granted requester is a plain array select.
  for (genvar g = 0; g < pNUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = i_data[g*pDATA_WIDTH +: pDATA_WIDTH];
  end

  // Only the granted requester's strobes reach the datapath.
  assign sel_valid_c = i_valid[idx_q];
  assign sel_last_c  = i_last[idx_q];
  assign sel_data_c  = data_arr[idx_q];

  rr_pick #(
    .pNUM_REQ (pNUM_REQ),
    .pIDX_W   (IDX_W)
  ) u_rr_pick (
    .req          (i_req),
    .ptr          (ptr_q),
    .winner_c     (pick_grant_c),
    .winner_idx_c (pick_idx_c),
    .found_c      (pick_found_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    grant_d = o_grant;
    dv_d    = 1'b0;
    fin_d   = 1'b0;
    data_d  = '0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found_c) begin
          idx_d   = pick_idx_c;
          grant_d = pick_grant_c;
          state_d = ST_FORM_REQUEST;
        end
      end

      // Requester must still want the port one cycle after the pick;
      // a withdrawn request leaves the pointer where it was.
      ST_FORM_REQUEST: begin
        if (i_req[idx_q]) begin
          beat_d  = '0;
          state_d = ST_XFER;
        end else begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end

      ST_XFER: begin
        if (sel_valid_c) begin
          dv_d   = 1'b1;
          data_d = sel_data_c;
          beat_d = beat_q + BEAT_W'(1);
          // The beat being accepted is number beat_q+1; reaching the limit
          // without a last marker aborts the frame on that same beat.
          if (sel_last_c || (beat_q == BEAT_W'(pMAX_LEN - 1))) begin
            fin_d   = 1'b1;
            err_d   = !sel_last_c;
            grant_d = '0;
            ptr_d   = idx_q;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end

      // Requests are not looked at until the gap has fully elapsed.
      ST_GAP: begin
        if (gap_q == GAP_W'(pIFG - 1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      ptr_q           <= IDX_W'(pNUM_REQ - 1);
      beat_q          <= '0;
      gap_q           <= '0;
      o_grant         <= '0;
      o_TX_data_valid <= 1'b0;
      o_TX_finish     <= 1'b0;
      o_data_TX       <= '0;
      o_busy          <= 1'b0;
      o_err_len       <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      ptr_q           <= ptr_d;
      beat_q          <= beat_d;
      gap_q           <= gap_d;
      o_grant         <= grant_d;
      o_TX_data_valid <= dv_d;
      o_TX_finish     <= fin_d;
      o_data_TX       <= data_d;
      o_busy          <= busy_d;
      o_err_len       <= err_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Self-checking bench for tx_port_arbiter: directed scenarios plus random
// traffic, compared every cycle against a frame-level reference model.
module tb_tx_port_arbiter;

  localparam int unsigned N      = 3;
  localparam int unsigned DW     = 8;
  localparam int unsigned IFG    = 20;
  localparam int unsigned MAXLEN = 1522;
  localparam int unsigned BUF    = 1600;

  logic              i_clk;
  logic              i_rst;
  logic [N-1:0]      i_req, i_valid, i_last;
  logic [N*DW-1:0]   i_data;
  logic [DW-1:0]     d [N];
  logic [N-1:0]      o_grant;
  logic              o_TX_data_valid, o_TX_finish, o_busy, o_err_len;
  logic [DW-1:0]     o_data_TX;
  logic [1:0]        o_state;

  tx_port_arbiter #(
    .pDATA_WIDTH (DW),
    .pNUM_REQ    (N),
    .pIFG        (IFG),
    .pMAX_LEN    (MAXLEN)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req           (i_req),
    .i_data          (i_data),
    .i_valid         (i_valid),
    .i_last          (i_last),
    .o_grant         (o_grant),
    .o_TX_data_valid (o_TX_data_valid),
    .o_TX_finish     (o_TX_finish),
    .o_data_TX       (o_data_TX),
    .o_state         (o_state),
    .o_busy          (o_busy),
    .o_err_len       (o_err_len)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always_comb begin
    for (int k = 0; k < N; k++) i_data[k*DW +: DW] = d[k];
  end

  int checks, errors;

  // Reference model: spec-level view (0 idle, 1 form, 2 xfer, 3 gap).
  int           m_st, m_sel, m_ptr, m_beats, m_gap_left;
  logic [N-1:0] e_grant;
  logic         e_dv, e_fin, e_err;
  logic [DW-1:0] e_data;

  // Per-requester frame sources.
  logic [DW-1:0] fbuf [N][BUF];
  int            flen [N];
  int            fpos [N];
  bit            fnoend [N];
  int            valid_pct;
  bit            rand_mode, auto_reload;
  logic [N-1:0]  force_mask;

  // Observation logs.
  int glog[$];
  int blog[$];
  int flog[$];
  int slog[$];
  int gap_cycles, err_cnt, err_bytes, err_grant, err_state, bsf;
  logic [1:0] prev_state;
  int t1_exp [4] = '{0, 1, 2, 0};
  int t2_exp [3] = '{11, 22, 33};
  int t2_sexp [4] = '{1, 2, 3, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_frame(input int k, input int len, input bit noend);
    for (int i = 0; i < len; i++) fbuf[k][i] = DW'($urandom);
    flen[k]   = len;
    fpos[k]   = 0;
    fnoend[k] = noend;
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int k = 0; k < N; k++) if (fpos[k] < flen[k]) p = 1'b1;
    return p;
  endfunction

  // Advance the reference by one clock using the inputs presented at the edge.
  task automatic model_step();
    e_dv = 1'b0; e_fin = 1'b0; e_err = 1'b0; e_data = '0;
    if (i_rst) begin
      m_st = 0; m_sel = 0; m_ptr = N - 1; m_beats = 0; m_gap_left = 0;
      e_grant = '0;
    end else begin
      case (m_st)
        0: begin
          for (int o = 1; o <= N; o++) begin
            int c;
            c = (m_ptr + o) % N;
            if (m_st == 0 && i_req[c]) begin
              m_sel = c;
              m_st  = 1;
              e_grant = '0;
              e_grant[c] = 1'b1;
            end
          end
        end
        1: begin
          if (i_req[m_sel]) begin
            m_st = 2; m_beats = 0;
          end else begin
            m_st = 0; e_grant = '0;
          end
        end
        2: begin
          if (i_valid[m_sel]) begin
            e_dv = 1'b1;
            e_data = d[m_sel];
            m_beats++;
            if (i_last[m_sel] || m_beats == MAXLEN) begin
              e_fin = 1'b1;
              e_err = !i_last[m_sel];
              e_grant = '0;
              m_ptr = m_sel;
              m_st = 3;
              m_gap_left = IFG;
            end
          end
        end
        default: begin
          m_gap_left--;
          if (m_gap_left == 0) m_st = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    chk("state",      32'(o_state),         32'(m_st));
    chk("busy",       32'(o_busy),          32'(m_st != 0));
    chk("grant",      32'(o_grant),         32'(e_grant));
    chk("data_valid", 32'(o_TX_data_valid), 32'(e_dv));
    chk("data",       32'(o_data_TX),       32'(e_data));
    chk("finish",     32'(o_TX_finish),     32'(e_fin));
    chk("err_len",    32'(o_err_len),       32'(e_err));
    chk("grant_1hot", 32'($onehot0(o_grant)), 32'd1);
    chk("data_zero",  32'(o_TX_data_valid ? 8'h00 : o_data_TX), 32'd0);
  endtask

  // Present inputs for the next edge; only the model-granted requester in
  // transfer gets real bytes, everyone else drives junk that must be ignored.
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bit active;
      active = (m_st == 2) && (m_sel == k);
      if (rand_mode && flen[k] == 0 && $urandom_range(15) == 0)
        load_frame(k, ($urandom_range(31) == 0) ? int'($urandom_range(60, 13))
                                                 : int'($urandom_range(12, 1)), 1'b0);
      i_req[k] = (fpos[k] < flen[k]) && !force_mask[k] &&
                 !(rand_mode && m_st == 1 && m_sel == k && $urandom_range(7) == 0);
      if (active && $urandom_range(99) < valid_pct) begin
        i_valid[k] = 1'b1;
        d[k]       = fbuf[k][fpos[k]];
        i_last[k]  = !fnoend[k] && (fpos[k] == flen[k] - 1);
      end else begin
        i_valid[k] = active ? 1'b0 : 1'($urandom_range(1));
        i_last[k]  = 1'($urandom_range(1));
        d[k]       = DW'($urandom);
      end
    end
  endtask

  task automatic tick();
    int gi;
    @(posedge i_clk);
    #1;
    model_step();
    if (i_rst) begin
      for (int k = 0; k < N; k++) if (fpos[k] > 0) begin flen[k] = 0; fpos[k] = 0; end
      bsf = 0;
    end else if (e_dv) begin
      fpos[m_sel]++;
      if (e_fin) begin
        flen[m_sel] = 0;
        fpos[m_sel] = 0;
        if (auto_reload) load_frame(m_sel, 4, 1'b0);
      end
    end
    compare_all();
    if (o_state == 2'b01) begin
      gi = -1;
      for (int k = 0; k < N; k++) if (o_grant[k]) gi = k;
      glog.push_back(gi);
    end
    if (o_TX_data_valid) begin blog.push_back(int'(o_data_TX)); bsf++; end
    if (o_TX_finish) begin flog.push_back(bsf); bsf = 0; end
    if (o_err_len) begin
      err_cnt++;
      err_bytes = blog.size();
      err_grant = int'(o_grant);
      err_state = int'(o_state);
    end
    if (o_state == 2'b11) gap_cycles++;
    if (o_state != prev_state) begin slog.push_back(int'(o_state)); prev_state = o_state; end
    if (auto_reload && glog.size() >= 4) auto_reload = 1'b0;
  endtask

  task automatic run_until_idle(input int max);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < max) begin
      drive();
      tick();
      n++;
      done = (m_st == 0) && !pending();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got=busy exp=idle after %0d cycles", n);
    end
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    repeat (n) begin drive(); tick(); end
    i_rst = 1'b0;
  endtask

  task automatic clear_logs();
    glog.delete(); blog.delete(); flog.delete(); slog.delete();
    gap_cycles = 0; err_cnt = 0; err_bytes = 0; err_grant = 0; err_state = 0; bsf = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    m_st = 0; m_sel = 0; m_ptr = N - 1; m_beats = 0; m_gap_left = 0;
    e_grant = '0; e_dv = 0; e_fin = 0; e_err = 0; e_data = '0;
    valid_pct = 100; rand_mode = 0; auto_reload = 0; force_mask = '0;
    prev_state = 2'b00;
    i_rst = 1'b1; i_req = '0; i_valid = '0; i_last = '0;
    for (int k = 0; k < N; k++) begin d[k] = '0; flen[k] = 0; fpos[k] = 0; fnoend[k] = 0; end
    clear_logs();

    // Reset state
    do_reset(3);
    chk("rst_state", 32'(o_state), 0);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_dv",    32'(o_TX_data_valid), 0);
    chk("rst_fin",   32'(o_TX_finish), 0);

    // All three requesting, 4-byte frames: order 0,1,2,0
    clear_logs();
    auto_reload = 1'b1;
    for (int k = 0; k < N; k++) load_frame(k, 4, 1'b0);
    run_until_idle(600);
    auto_reload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_order%0d", i), 32'((i < glog.size()) ? glog[i] : -1), 32'(t1_exp[i]));
      chk($sformatf("fin_on_4th%0d", i), 32'((i < flog.size()) ? flog[i] : -1), 32'd4);
    end

    // Single 3-byte frame from requester 0
    do_reset(1);
    clear_logs();
    fbuf[0][0] = 8'd11; fbuf[0][1] = 8'd22; fbuf[0][2] = 8'd33;
    flen[0] = 3; fpos[0] = 0; fnoend[0] = 1'b0;
    run_until_idle(100);
    chk("t2_nbytes", 32'(blog.size()), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2_byte%0d", i), 32'((i < blog.size()) ? blog[i] : -1), 32'(t2_exp[i]));
    chk("t2_fin_pos", 32'((flog.size() == 1) ? flog[0] : -1), 3);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_state%0d", i), 32'((i < slog.size()) ? slog[i] : -1), 32'(t2_sexp[i]));
    chk("t2_gap_len", 32'(gap_cycles), IFG);

    // Requester 1 withdraws during FORM_REQUEST
    clear_logs();
    load_frame(1, 5, 1'b0);
    drive(); tick();
    force_mask[1] = 1'b1;
    drive(); tick();
    chk("t3_abort_state", 32'(o_state), 0);
    chk("t3_abort_grant", 32'(o_grant), 0);
    chk("t3_abort_dv",    32'(o_TX_data_valid), 0);
    force_mask = '0;
    load_frame(2, 3, 1'b0);
    run_until_idle(200);
    chk("t3_first_served", 32'((glog.size() > 1) ? glog[1] : -1), 1);
    chk("t3_then",         32'((glog.size() > 2) ? glog[2] : -1), 2);
    chk("t3_nbytes",       32'(blog.size()), 8);

    // Oversize frame from requester 0, never marked last
    clear_logs();
    load_frame(0, 1600, 1'b1);
    run_until_idle(2000);
    chk("t4_err_cnt",   32'(err_cnt), 1);
    chk("t4_err_byte",  32'(err_bytes), MAXLEN);
    chk("t4_err_grant", 32'(err_grant), 0);
    chk("t4_err_state", 32'(err_state), 3);
    chk("t4_fin_pos",   32'((flog.size() == 1) ? flog[0] : -1), MAXLEN);
    chk("t4_gap_len",   32'(gap_cycles), IFG);

    // Reset at beat 10 of a frame from requester 1
    clear_logs();
    load_frame(1, 30, 1'b0);
    n = 0;
    while (!(m_st == 2 && m_beats == 10) && n < 100) begin drive(); tick(); n++; end
    chk("t5_reached_beat10", 32'(m_beats), 10);
    i_rst = 1'b1;
    drive(); tick();
    i_rst = 1'b0;
    chk("t5_rst_grant", 32'(o_grant), 0);
    chk("t5_rst_dv",    32'(o_TX_data_valid), 0);
    chk("t5_rst_data",  32'(o_data_TX), 0);
    chk("t5_rst_fin",   32'(o_TX_finish), 0);
    chk("t5_rst_err",   32'(o_err_len), 0);
    chk("t5_rst_state", 32'(o_state), 0);
    chk("t5_rst_busy",  32'(o_busy), 0);
    chk("t5_no_finish", 32'(flog.size()), 0);
    clear_logs();
    load_frame(0, 5, 1'b0);
    load_frame(1, 5, 1'b0);
    run_until_idle(200);
    chk("t5_first_after_rst", 32'((glog.size() > 0) ? glog[0] : -1), 0);
    chk("t5_second",          32'((glog.size() > 1) ? glog[1] : -1), 1);

    // Random traffic with gaps, withdrawals and occasional resets
    clear_logs();
    valid_pct = 70;
    rand_mode = 1'b1;
    repeat (6000) begin
      i_rst = ($urandom_range(2499) == 0);
      drive();
      tick();
    end
    rand_mode = 1'b0;
    i_rst = 1'b0;
    run_until_idle(800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
